seq_multdiv: RTL and testbench

SEQ_MULTDIV -- requirements
Module: seq_multdiv

---
 rtl/multdiv_pkg.sv | 22 ++
 rtl/multdiv_ctrl.sv | 67 ++++++
 rtl/seq_multdiv.sv | 161 ++++++++++++++++
 tb/tb_seq_multdiv.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/multdiv_pkg.sv
// +-----------------------------------------------------------------------+
// | multdiv_pkg : shared FSM-state and operation encodings for seq_multdiv |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

package multdiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic {
    OP_MULT = 1'b0,
    OP_DIV  = 1'b1
  } op_e;

endpackage

`default_nettype wire

// File: rtl/multdiv_ctrl.sv
// +-----------------------------------------------------------------------+
// | multdiv_ctrl : IDLE/RUN/DONE sequencer, iteration counter, busy/RDY   |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module multdiv_ctrl
  import multdiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic start_i,
  output logic accept_o,
  output logic step_o,
  output logic last_o,
  output logic busy_o,
  output logic rdy_o
);

  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN: begin
        if (cnt_q == C_LAST) state_d = DONE;
        else                 cnt_d   = cnt_q + 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    accept_o = (state_q == IDLE) && start_i;
    step_o   = (state_q == RUN);
    last_o   = (state_q == RUN) && (cnt_q == C_LAST);
    busy_o   = (state_q != IDLE);
    rdy_o    = (state_q == DONE);
  end

endmodule

`default_nettype wire

// File: rtl/seq_multdiv.sv
// +-----------------------------------------------------------------------+
// | seq_multdiv : iterative signed multiply (Booth) / divide (restoring)  |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module seq_multdiv
  import multdiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam logic [WIDTH-1:0] C_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? ('0 - v) : v;
  endfunction

  logic w_accept, w_step, w_last;

  multdiv_ctrl #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_ctrl (
    .clk_i    (clock),
    .rst_n_i  (resetn),
    .start_i  (ctrl_MULT | ctrl_DIV),
    .accept_o (w_accept),
    .step_o   (w_step),
    .last_o   (w_last),
    .busy_o   (busy),
    .rdy_o    (data_resultRDY)
  );

  // hi holds the Booth accumulator (one guard bit) or the division remainder;
  // lo holds the multiplier being scanned or the dividend/quotient shift word.
  logic [WIDTH:0]   hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic             bit_q, bit_d;
  op_e              op_q, op_d;
  logic             neg_q, neg_d;
  logic             dz_q, dz_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             exc_q, exc_d;

  logic [WIDTH:0]   m_ext, booth_sum, rem_sh;
  logic [WIDTH-1:0] rem_sub;
  logic             rem_ge;

  always_comb begin
    m_ext = {m_q[WIDTH-1], m_q};
    case ({lo_q[0], bit_q})
      2'b01:   booth_sum = hi_q + m_ext;
      2'b10:   booth_sum = hi_q - m_ext;
      default: booth_sum = hi_q;
    endcase
    rem_sh  = {hi_q[WIDTH-1:0], lo_q[WIDTH-1]};
    rem_ge  = (rem_sh >= {1'b0, m_q});
    rem_sub = rem_sh[WIDTH-1:0] - m_q;
  end

  always_comb begin
    hi_d     = hi_q;
    lo_d     = lo_q;
    m_d      = m_q;
    bit_d    = bit_q;
    op_d     = op_q;
    neg_d    = neg_q;
    dz_d     = dz_q;
    ovf_d    = ovf_q;
    result_d = result_q;
    exc_d    = exc_q;
    if (w_accept) begin
      hi_d  = '0;
      bit_d = 1'b0;
      if (ctrl_MULT) begin
        op_d  = OP_MULT;
        lo_d  = data_operandB;
        m_d   = data_operandA;
        neg_d = 1'b0;
        dz_d  = 1'b0;
        ovf_d = 1'b0;
      end else begin
        op_d  = OP_DIV;
        lo_d  = mag(data_operandA);
        m_d   = mag(data_operandB);
        neg_d = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
        dz_d  = (data_operandB == '0);
        ovf_d = (data_operandA == C_MIN) && (data_operandB == '1);
      end
    end else if (w_step) begin
      if (op_q == OP_MULT) begin
        hi_d  = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
        lo_d  = {booth_sum[0], lo_q[WIDTH-1:1]};
        bit_d = lo_q[0];
      end else begin
        hi_d = {1'b0, (rem_ge ? rem_sub : rem_sh[WIDTH-1:0])};
        lo_d = {lo_q[WIDTH-2:0], rem_ge};
      end
      // The final iteration's outcome is registered directly into the result.
      if (w_last) begin
        if (op_q == OP_MULT) begin
          result_d = lo_d;
          exc_d    = (hi_d[WIDTH-1:0] != {WIDTH{lo_d[WIDTH-1]}});
        end else if (dz_q) begin
          result_d = '0;
          exc_d    = 1'b1;
        end else begin
          result_d = neg_q ? ('0 - lo_d) : lo_d;
          exc_d    = ovf_q;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      hi_q     <= '0;
      lo_q     <= '0;
      m_q      <= '0;
      bit_q    <= 1'b0;
      op_q     <= OP_MULT;
      neg_q    <= 1'b0;
      dz_q     <= 1'b0;
      ovf_q    <= 1'b0;
      result_q <= '0;
      exc_q    <= 1'b0;
    end else begin
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      m_q      <= m_d;
      bit_q    <= bit_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      dz_q     <= dz_d;
      ovf_q    <= ovf_d;
      result_q <= result_d;
      exc_q    <= exc_d;
    end
  end

  assign data_result    = result_q;
  assign data_exception = exc_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_multdiv.sv
// +-----------------------------------------------------------------------+
// | tb_seq_multdiv : directed scoreboard bench for seq_multdiv, WIDTH=32  |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module tb_seq_multdiv;

  typedef struct packed {
    logic [31:0] res;
    logic        exc;
  } exp_t;

  logic        clock = 1'b0;
  logic        resetn;
  logic [31:0] data_operandA, data_operandB;
  logic        ctrl_MULT, ctrl_DIV;
  logic [31:0] data_result;
  logic        data_exception, data_resultRDY, busy;

  int   vectors = 0;
  int   miscompares = 0;
  exp_t sb[$];

  seq_multdiv #(.WIDTH(32)) dut (
    .clock          (clock),
    .resetn         (resetn),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drives a start for the edge that becomes edge 1; returns #1 after it.
  task automatic start_op(input logic mul, input logic div,
                          input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    ctrl_MULT = mul;
    ctrl_DIV  = div;
    data_operandA = a;
    data_operandB = b;
    @(posedge clock);
    #1;
    ctrl_MULT = 1'b0;
    ctrl_DIV  = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  task automatic push_exp(input logic [31:0] r, input logic e);
    exp_t x;
    x.res = r;
    x.exc = e;
    sb.delete();
    sb.push_back(x);
  endtask

  // Follows one operation from edge 1; optionally pulses ctrl inputs for edge inj_edge.
  task automatic run_check(input string tag, input int inj_edge,
                           input logic inj_mul, input logic inj_div);
    int   n;
    int   rdy_at;
    int   busy_n;
    exp_t e;
    n = 1;
    rdy_at = 0;
    busy_n = 0;
    while (n <= 40 && !(rdy_at != 0 && n == rdy_at + 1)) begin
      if (busy) busy_n++;
      if (data_resultRDY && rdy_at == 0) begin
        rdy_at = n;
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk({tag, " result"}, {32'd0, data_result}, {32'd0, e.res});
          chk({tag, " exception"}, {63'd0, data_exception}, {63'd0, e.exc});
        end else begin
          chk({tag, " unexpected RDY"}, 64'd1, 64'd0);
        end
      end
      if (n + 1 == inj_edge) begin
        ctrl_MULT = inj_mul;
        ctrl_DIV  = inj_div;
      end
      @(posedge clock);
      #1;
      n++;
      if (n == inj_edge) begin
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
      end
    end
    chk({tag, " rdy edge"}, 64'(rdy_at), 64'd33);
    chk({tag, " busy cycles"}, 64'(busy_n), 64'd33);
    chk({tag, " rdy after"}, {63'd0, data_resultRDY}, 64'd0);
    chk({tag, " busy after"}, {63'd0, busy}, 64'd0);
  endtask

  initial begin
    resetn = 1'b0;
    ctrl_MULT = 1'b0;
    ctrl_DIV = 1'b0;
    data_operandA = 32'd0;
    data_operandB = 32'd0;
    #12;
    chk("reset result", {32'd0, data_result}, 64'd0);
    chk("reset exception", {63'd0, data_exception}, 64'd0);
    chk("reset rdy", {63'd0, data_resultRDY}, 64'd0);
    chk("reset busy", {63'd0, busy}, 64'd0);
    @(negedge clock);
    resetn = 1'b1;

    push_exp(-32'sd42, 1'b0);
    start_op(1'b1, 1'b0, 32'd7, -32'sd6);
    run_check("mult 7*-6", 0, 1'b0, 1'b0);

    push_exp(32'h0000_0000, 1'b1);
    start_op(1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000);
    run_check("mult ovf", 0, 1'b0, 1'b0);

    push_exp(32'd1, 1'b0);
    start_op(1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_check("mult -1*-1", 0, 1'b0, 1'b0);

    push_exp(-32'sd3, 1'b0);
    start_op(1'b0, 1'b1, -32'sd15, 32'd4);
    run_check("div -15/4", 0, 1'b0, 1'b0);

    // A start held for the DONE->IDLE edge must be ignored.
    push_exp(32'd14, 1'b0);
    start_op(1'b0, 1'b1, 32'd100, 32'd7);
    run_check("div 100/7", 34, 1'b1, 1'b0);

    push_exp(32'd0, 1'b1);
    start_op(1'b0, 1'b1, 32'd5, 32'd0);
    run_check("div by zero", 0, 1'b0, 1'b0);

    push_exp(32'h8000_0000, 1'b1);
    start_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    run_check("div min/-1", 0, 1'b0, 1'b0);

    push_exp(32'd9, 1'b0);
    start_op(1'b1, 1'b0, 32'd3, 32'd3);
    run_check("mult 3*3 div ignored", 5, 1'b0, 1'b1);

    push_exp(32'd18, 1'b0);
    start_op(1'b1, 1'b1, 32'd6, 32'd3);
    run_check("both starts", 0, 1'b0, 1'b0);

    // Abort a divide at edge 10.
    sb.delete();
    start_op(1'b0, 1'b1, 32'd100, 32'd7);
    repeat (9) @(posedge clock);
    #1;
    resetn = 1'b0;
    #1;
    chk("abort result", {32'd0, data_result}, 64'd0);
    chk("abort exception", {63'd0, data_exception}, 64'd0);
    chk("abort rdy", {63'd0, data_resultRDY}, 64'd0);
    chk("abort busy", {63'd0, busy}, 64'd0);
    repeat (3) @(posedge clock);
    @(negedge clock);
    resetn = 1'b1;
    repeat (30) @(posedge clock);
    #1;
    chk("post-abort rdy", {63'd0, data_resultRDY}, 64'd0);
    chk("post-abort busy", {63'd0, busy}, 64'd0);

    push_exp(32'd6, 1'b0);
    start_op(1'b1, 1'b0, 32'd2, 32'd3);
    run_check("mult 2*3 after abort", 0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
